// File: rtl/ram_ctrl_pkg.sv
// Shared types for the two-master RAM arbiter: controller states,
// master identifiers and the read-response tag.
package ram_ctrl_pkg;

    typedef enum logic {
        CLR = 1'b0,
        RUN = 1'b1
    } ctrl_state_t;

    typedef logic master_id_t;

    localparam master_id_t M0 = 1'b0;
    localparam master_id_t M1 = 1'b1;

    // Identifies which master owns the read data coming back next cycle.
    typedef struct packed {
        logic       valid;
        master_id_t id;
    } rsp_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from the
// requests and the registered priority pointer; the pointer flips to
// the other master after every grant and holds when nothing is granted.
module rr_arb2
    import ram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    master_id_t r_prio;

    // Pick the single requester, or the prioritised one on a tie.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (r_prio == M0) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Hand priority to the master that was not just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= M0;
        end else if (gnt[0]) begin
            r_prio <= M1;
        end else if (gnt[1]) begin
            r_prio <= M0;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port-pair RAM between masters m0 and m1. One access
// per cycle, read data returns one cycle after acceptance, and the RAM is
// cleared for one cycle after reset and after every soft-clear request.
module ram_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,

    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic                  ram_rst,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_din,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_dout
);

    ctrl_state_t r_state;
    rsp_tag_t    r_tag;
    logic        w_arb_en;
    logic [1:0]  w_gnt;
    master_id_t  w_gnt_id;

    // Controller: one clearing cycle, then serve requests until a soft clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLR;
        end else begin
            case (r_state)
                CLR:     r_state <= RUN;
                RUN:     if (clr) r_state <= CLR;
                default: r_state <= CLR;
            endcase
        end
    end

    // A pending clear wins over any request in the same cycle.
    assign w_arb_en = (r_state == RUN) && !clr;
    assign ram_rst  = (r_state == CLR);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_arb_en),
        .req   ({m1_valid, m0_valid}),
        .gnt   (w_gnt)
    );

    assign m0_ready = w_gnt[0];
    assign m1_ready = w_gnt[1];
    assign w_gnt_id = w_gnt[1] ? M1 : M0;

    // Route the granted master's request onto the RAM ports; idle ports stay at zero.
    always_comb begin
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_wr_addr = '0;
        ram_wr_din  = '0;
        ram_rd_addr = '0;
        if (w_gnt[0]) begin
            if (m0_we) begin
                ram_we      = 1'b1;
                ram_wr_addr = m0_addr;
                ram_wr_din  = m0_wdata;
            end else begin
                ram_re      = 1'b1;
                ram_rd_addr = m0_addr;
            end
        end else if (w_gnt[1]) begin
            if (m1_we) begin
                ram_we      = 1'b1;
                ram_wr_addr = m1_addr;
                ram_wr_din  = m1_wdata;
            end else begin
                ram_re      = 1'b1;
                ram_rd_addr = m1_addr;
            end
        end
    end

    // Remember who issued this cycle's read so the data can be steered next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag <= '0;
        end else begin
            r_tag.valid <= ram_re;
            r_tag.id    <= w_gnt_id;
        end
    end

    assign m0_rvalid = r_tag.valid && (r_tag.id == M0);
    assign m1_rvalid = r_tag.valid && (r_tag.id == M1);
    assign m0_rdata  = m0_rvalid ? ram_rd_dout : '0;
    assign m1_rdata  = m1_rvalid ? ram_rd_dout : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter with a behavioural RAM beside it. A monitor keeps
// a shadow memory and a queue of expected read responses; each test task
// drives one scenario and checks grants and RAM port activity inline.
module tb_ram_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          m0_valid, m0_ready, m0_we, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_valid, m1_ready, m1_we, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          ram_rst, ram_we, ram_re;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_wr_din, ram_rd_dout;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] shadow[16];
    logic          mon_en = 1'b0;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .m0_valid    (m0_valid),
        .m0_ready    (m0_ready),
        .m0_we       (m0_we),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_rvalid   (m0_rvalid),
        .m0_rdata    (m0_rdata),
        .m1_valid    (m1_valid),
        .m1_ready    (m1_ready),
        .m1_we       (m1_we),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_rvalid   (m1_rvalid),
        .m1_rdata    (m1_rdata),
        .ram_rst     (ram_rst),
        .ram_we      (ram_we),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_din  (ram_wr_din),
        .ram_re      (ram_re),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_dout (ram_rd_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: synchronous clear, registered read.
    logic [DW-1:0] mem[16];
    always @(posedge clk) begin
        if (ram_rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            ram_rd_dout <= '0;
        end else begin
            if (ram_we) mem[ram_wr_addr] <= ram_wr_din;
            if (ram_re) ram_rd_dout <= mem[ram_rd_addr];
        end
    end

    // Response monitor: pops the expectation queued one cycle earlier, then
    // records any transfer happening in the current cycle.
    logic [1:0]    mon_exp_rv;
    logic [DW-1:0] mon_exp_d;
    exp_t          mon_e;
    always @(negedge clk) begin
        if (mon_en) begin
            mon_exp_rv = 2'b00;
            mon_exp_d  = '0;
            if (sb.size() > 0) begin
                mon_e      = sb.pop_front();
                mon_exp_rv = mon_e.id ? 2'b10 : 2'b01;
                mon_exp_d  = mon_e.data;
            end
            n_cmp++;
            if ({m1_rvalid, m0_rvalid} !== mon_exp_rv) begin
                n_bad++;
                $display("FAIL rvalid t=%0t got m1/m0=%b want %b", $time, {m1_rvalid, m0_rvalid}, mon_exp_rv);
            end else if (mon_exp_rv != 2'b00) begin
                n_cmp++;
                if (mon_exp_rv[1] ? (m1_rdata !== mon_exp_d || m0_rdata !== '0)
                                  : (m0_rdata !== mon_exp_d || m1_rdata !== '0)) begin
                    n_bad++;
                    $display("FAIL rdata t=%0t got m0=%h m1=%h want %h on m%0d", $time, m0_rdata, m1_rdata, mon_exp_d, mon_exp_rv[1]);
                end
            end
            if (m0_valid && m0_ready) begin
                if (m0_we) shadow[m0_addr] = m0_wdata;
                else sb.push_back('{id: 1'b0, data: shadow[m0_addr]});
            end
            if (m1_valid && m1_ready) begin
                if (m1_we) shadow[m1_addr] = m1_wdata;
                else sb.push_back('{id: 1'b1, data: shadow[m1_addr]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_shadow();
        for (int i = 0; i < 16; i++) shadow[i] = '0;
    endtask

    task automatic idle_inputs();
        m0_valid = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_valid = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        clr = 0;
    endtask

    // Reset, then advance through the single CLR cycle into RUN.
    task automatic reset_dut();
        mon_en = 0;
        sb.delete();
        idle_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        clear_shadow();
        mon_en = 1;
        step();
    endtask

    task automatic test_reset();
        m0_valid = 1; m0_we = 0; m0_addr = 4'd7;
        m1_valid = 1; m1_we = 0; m1_addr = 4'd8;
        rst_n = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ram_rst !== 1'b1 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold cyc%0d got rst=%b rdy=%b%b want 1 00", c, ram_rst, m1_ready, m0_ready);
            end
            n_cmp++;
            if ({m0_rvalid, m1_rvalid, ram_we, ram_re} !== 4'b0 || m0_rdata !== '0 || m1_rdata !== '0
                || ram_wr_addr !== '0 || ram_rd_addr !== '0 || ram_wr_din !== '0) begin
                n_bad++;
                $display("FAIL reset_outs got rv=%b%b we=%b re=%b rd=%h/%h want all zero", m1_rvalid, m0_rvalid, ram_we, ram_re, m0_rdata, m1_rdata);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        clear_shadow();
        mon_en = 1;
        @(negedge clk);
        n_cmp++;
        if (ram_rst !== 1'b1 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_cycle got rst=%b rdy=%b%b want 1 00", ram_rst, m1_ready, m0_ready);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (ram_rst !== 1'b0 || m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL first_grant got rst=%b rdy=%b%b want 0 01", ram_rst, m1_ready, m0_ready);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_write_read();
        m0_valid = 1; m0_we = 1; m0_addr = 4'd3; m0_wdata = 8'hA5;
        @(negedge clk);
        n_cmp++;
        if (m0_ready !== 1'b1 || ram_we !== 1'b1 || ram_re !== 1'b0 || ram_wr_addr !== 4'd3 || ram_wr_din !== 8'hA5) begin
            n_bad++;
            $display("FAIL wr_port got rdy=%b we=%b re=%b a=%h d=%h want 1 1 0 3 a5", m0_ready, ram_we, ram_re, ram_wr_addr, ram_wr_din);
        end
        step();
        m0_valid = 0; m0_we = 0;
        m1_valid = 1; m1_we = 0; m1_addr = 4'd3;
        @(negedge clk);
        n_cmp++;
        if (m1_ready !== 1'b1 || ram_re !== 1'b1 || ram_we !== 1'b0 || ram_rd_addr !== 4'd3) begin
            n_bad++;
            $display("FAIL rd_port got rdy=%b re=%b we=%b a=%h want 1 1 0 3", m1_ready, ram_re, ram_we, ram_rd_addr);
        end
        step();
        m1_valid = 0;
        @(negedge clk);
        n_cmp++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 8'hA5 || m0_rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL raw_read got m1rv=%b d=%h m0rv=%b want 1 a5 0", m1_rvalid, m1_rdata, m0_rvalid);
        end
        step();
    endtask

    task automatic test_fairness();
        logic [1:0] want;
        reset_dut();
        m0_valid = 1; m0_we = 0; m0_addr = 4'd1;
        m1_valid = 1; m1_we = 0; m1_addr = 4'd2;
        for (int k = 0; k < 6; k++) begin
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            n_cmp++;
            if ({m1_ready, m0_ready} !== want) begin
                n_bad++;
                $display("FAIL fair_grant k=%0d got %b want %b", k, {m1_ready, m0_ready}, want);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_soft_clear();
        for (int i = 0; i < 16; i++) begin
            m0_valid = 1; m0_we = 1; m0_addr = i[AW-1:0]; m0_wdata = 8'h10 + i[DW-1:0];
            @(negedge clk);
            n_cmp++;
            if (m0_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL fill_ready i=%0d got %b want 1", i, m0_ready);
            end
            step();
        end
        m0_valid = 0; m0_we = 0;
        m1_valid = 1; m1_we = 0; m1_addr = 4'd5;
        step();
        clr = 1;
        @(negedge clk);
        n_cmp++;
        if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || m1_rvalid !== 1'b1 || m1_rdata !== 8'h15) begin
            n_bad++;
            $display("FAIL clr_req got rdy=%b%b rv=%b d=%h want 00 1 15", m1_ready, m0_ready, m1_rvalid, m1_rdata);
        end
        step();
        clr = 0;
        clear_shadow();
        @(negedge clk);
        n_cmp++;
        if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || ram_rst !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_state got rdy=%b%b rst=%b want 00 1", m1_ready, m0_ready, ram_rst);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (m1_ready !== 1'b1 || ram_rst !== 1'b0) begin
            n_bad++;
            $display("FAIL post_clr_grant got rdy=%b rst=%b want 1 0", m1_ready, ram_rst);
        end
        step();
        m1_valid = 0;
        @(negedge clk);
        n_cmp++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 8'h00) begin
            n_bad++;
            $display("FAIL post_clr_data got rv=%b d=%h want 1 00", m1_rvalid, m1_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid_read();
        m0_valid = 1; m0_we = 1; m0_addr = 4'd9; m0_wdata = 8'h3C;
        step();
        m0_valid = 0; m0_we = 0;
        m1_valid = 1; m1_we = 0; m1_addr = 4'd9;
        @(negedge clk);
        n_cmp++;
        if (m1_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_accept got %b want 1", m1_ready);
        end
        step();
        n_cmp++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 8'h3C) begin
            n_bad++;
            $display("FAIL mid_resp got rv=%b d=%h want 1 3c", m1_rvalid, m1_rdata);
        end
        m0_valid = 1; m0_addr = 4'd9;
        m1_valid = 1;
        #1;
        rst_n = 0;
        mon_en = 0;
        sb.delete();
        #1;
        n_cmp++;
        if (m1_rvalid !== 1'b0 || m1_rdata !== '0 || m0_rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_drop got rv=%b%b d=%h want 00 00", m1_rvalid, m0_rvalid, m1_rdata);
        end
        step();
        step();
        rst_n = 1;
        clear_shadow();
        mon_en = 1;
        step();
        @(negedge clk);
        n_cmp++;
        if ({m1_ready, m0_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL mid_tie got %b want 01", {m1_ready, m0_ready});
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 16; i++) begin
            m0_valid = 1; m0_we = 1; m0_addr = i[AW-1:0]; m0_wdata = 8'h40 + i[DW-1:0];
            step();
        end
        m0_valid = 0; m0_we = 0;
        for (int i = 0; i < 16; i++) begin
            m1_valid = 1; m1_we = 0; m1_addr = i[AW-1:0];
            @(negedge clk);
            n_cmp++;
            if (m1_ready !== 1'b1 || ram_rd_addr !== i[AW-1:0]) begin
                n_bad++;
                $display("FAIL stream_ready i=%0d got rdy=%b a=%h", i, m1_ready, ram_rd_addr);
            end
            step();
        end
        m1_valid = 0;
        step();
        step();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 0;
        clear_shadow();
        step();
        test_reset();
        test_write_read();
        test_fairness();
        test_soft_clear();
        test_reset_mid_read();
        test_streaming();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
